// File: rtl/capture_pkg.sv
// Shared types and constants for the capture line writer: FSM states, per-pixel
// FIFO side-band metadata and the word-address helper.
package capture_pkg;

    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DONE} cap_state_e;

    localparam int WORD_BYTES     = 4;
    localparam int DIM_W          = 24;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_AW_DEF    = 4;

    // Each queued pixel carries its own position so a dropped pixel leaves a hole
    // instead of shifting later pixels onto the wrong column.
    typedef struct packed {
        logic [DIM_W-1:0] col;
        logic             odd;
        logic             eol;
        logic             eof;
    } pix_meta_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [DIM_W-1:0] col);
        return base + ({8'd0, col} * 32'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO with full/empty flags and a registered read port. A push at
// full succeeds when a pop happens in the same cycle.
module capture_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [W-1:0]  rd_data_q;
    logic          rd_fire, wr_fire;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign rd_fire   = rd_en_i && !empty_o;
    assign wr_fire   = wr_en_i && (!full_o || rd_fire);
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + (AW+1)'(wr_fire) - (AW+1)'(rd_fire);
        end
    end

endmodule

// File: rtl/capture_line_writer.sv
// Writes a non-backpressurable pixel stream line by line into ping-pong buffers
// over an Avalon-MM master. Optional CAPTURE_FRAME_COUNT_EN adds frame_count.
module capture_line_writer
    import capture_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_AW    = FIFO_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_capture,
    input  logic [23:0]       capture_width,
    input  logic [23:0]       capture_height,
    input  logic [31:0]       buff0,
    input  logic [31:0]       buff1,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic [31:0]       avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              buff0full,
    output logic              buff1full,
    output logic              capture_standby,
`ifdef CAPTURE_FRAME_COUNT_EN
    output logic [15:0]       frame_count,
`endif
    output logic              overflow
);

    localparam int ENT_W = DATA_W + $bits(pix_meta_t);

    cap_state_e       state_q, state_d;
    logic             start_prev_q;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0] col_in_q, col_in_d, row_in_q, row_in_d;
    logic [31:0]      buff0_q, buff0_d, buff1_q, buff1_d;
    logic             in_done_q, in_done_d;
    logic             overflow_q, overflow_d;
    logic             out_vld_q, out_vld_d;
    logic             full0_q, full0_d, full1_q, full1_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    pix_meta_t        push_meta, out_meta;
    logic [DATA_W-1:0] out_data;
    logic [ENT_W-1:0] fifo_rd;
    logic             push, pop, acc, fifo_full, fifo_empty;
    logic             arm_edge, last_col, last_row;

    assign arm_edge = start_capture && !start_prev_q;
    assign last_col = (col_in_q == width_q - DIM_W'(1));
    assign last_row = (row_in_q == height_q - DIM_W'(1));
    assign push     = in_valid && ((state_q == ARM && in_sof) || (state_q == ACTIVE && !in_done_q));
    assign acc      = out_vld_q && !avm_waitrequest;
    assign pop      = !fifo_empty && (!out_vld_q || acc);

    always_comb begin
        push_meta     = '0;
        push_meta.col = col_in_q;
        push_meta.odd = row_in_q[0];
        push_meta.eol = last_col;
        push_meta.eof = last_col && last_row;
    end

    capture_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (push),
        .wr_data_i({push_meta, in_data}),
        .rd_en_i  (pop),
        .rd_data_o(fifo_rd),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign {out_meta, out_data} = fifo_rd;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        buff0_d     = buff0_q;
        buff1_d     = buff1_q;
        col_in_d    = col_in_q;
        row_in_d    = row_in_q;
        in_done_d   = in_done_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        full0_d     = 1'b0;
        full1_d     = 1'b0;
        out_vld_d   = pop ? 1'b1 : (acc ? 1'b0 : out_vld_q);

        case (state_q)
            IDLE: if (arm_edge) begin
                width_d    = capture_width;
                height_d   = capture_height;
                buff0_d    = buff0;
                buff1_d    = buff1;
                col_in_d   = '0;
                row_in_d   = '0;
                in_done_d  = 1'b0;
                overflow_d = 1'b0;
                state_d    = (capture_width == '0 || capture_height == '0) ? DONE : ARM;
            end
            ARM: if (in_valid && in_sof) state_d = ACTIVE;
            ACTIVE: begin
                // Second term retires a frame whose final pixel was dropped on overflow.
                if ((acc && out_meta.eof) || (in_done_q && fifo_empty && !out_vld_q)) begin
                    state_d     = DONE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            DONE: if (!start_capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            if (fifo_full && !pop) overflow_d = 1'b1;
            if (last_col) begin
                col_in_d = '0;
                row_in_d = row_in_q + DIM_W'(1);
                if (last_row) in_done_d = 1'b1;
            end else begin
                col_in_d = col_in_q + DIM_W'(1);
            end
        end

        if (acc && out_meta.eol) begin
            full0_d = !out_meta.odd;
            full1_d = out_meta.odd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            buff0_q      <= '0;
            buff1_q      <= '0;
            col_in_q     <= '0;
            row_in_q     <= '0;
            in_done_q    <= 1'b0;
            overflow_q   <= 1'b0;
            out_vld_q    <= 1'b0;
            full0_q      <= 1'b0;
            full1_q      <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_capture;
            width_q      <= width_d;
            height_q     <= height_d;
            buff0_q      <= buff0_d;
            buff1_q      <= buff1_d;
            col_in_q     <= col_in_d;
            row_in_q     <= row_in_d;
            in_done_q    <= in_done_d;
            overflow_q   <= overflow_d;
            out_vld_q    <= out_vld_d;
            full0_q      <= full0_d;
            full1_q      <= full1_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign avm_write       = out_vld_q;
    assign avm_address     = out_vld_q ? word_addr(out_meta.odd ? buff1_q : buff0_q, out_meta.col) : '0;
    assign avm_writedata   = out_vld_q ? out_data : '0;
    assign buff0full       = full0_q;
    assign buff1full       = full1_q;
    assign capture_standby = (state_q == IDLE);
    assign overflow        = overflow_q;
`ifdef CAPTURE_FRAME_COUNT_EN
    assign frame_count     = frame_cnt_q;
`else
    logic unused_frame_cnt;
    assign unused_frame_cnt = ^frame_cnt_q;
`endif

endmodule
